// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame path.
// Optional feature macro: LED_BRIGHTNESS_EN (global brightness scaling).
package led_pkg;

  localparam int RGB_W = 24;
  localparam int G_MSB = 23;
  localparam int R_MSB = 15;
  localparam int B_MSB = 7;

  typedef enum logic [2:0] {
    IDLE, FETCH, SCALE, PRESENT, LOAD, GAP, LATCH, DONE
  } seq_state_t;

  // (c * (b + 1)) >> 8: b=255 is identity, b=0 is black.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/led_pixel_ram.sv
// Pixel buffer: one write port, one registered read port; out-of-range writes are dropped.
module led_pixel_ram
  import led_pkg::*;
#(
  parameter int DEPTH  = 60,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [RGB_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RGB_W-1:0]  rd_data
);

  logic [RGB_W-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH))
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams the pixel buffer to the WS2812 serialiser one word at a time, then holds the latch gap.
// Optional feature macro: LED_BRIGHTNESS_EN adds a per-pixel SCALE stage.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 60,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 7200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic [7:0]        brightness,
  output logic [23:0]       drv_rgb,
  output logic              drv_load,
  input  logic              drv_done,
  output logic              busy,
  output logic              frame_done
);

  localparam int                CNT_W     = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  LATCH_END = CNT_W'(LATCH_CYCLES - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  lcnt;
  logic [RGB_W-1:0]  rd_data;
  logic [RGB_W-1:0]  pix;
  logic [RGB_W-1:0]  rgb_hold;

  led_pixel_ram #(
    .DEPTH  (NUM_LEDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

`ifdef LED_BRIGHTNESS_EN
  logic [RGB_W-1:0] scaled;

  always_ff @(posedge clk)
    if (state == SCALE)
      scaled <= {scale_byte(rd_data[G_MSB -: 8], brightness),
                 scale_byte(rd_data[R_MSB -: 8], brightness),
                 scale_byte(rd_data[B_MSB -: 8], brightness)};

  assign pix = scaled;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pix = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      lcnt     <= '0;
      rgb_hold <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (start) idx <= '0;
        PRESENT: rgb_hold <= pix;
        GAP:     if (idx == LAST_IDX) lcnt <= '0;
                 else                 idx  <= idx + 1'b1;
        LATCH:   lcnt <= lcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
`ifdef LED_BRIGHTNESS_EN
      FETCH:   state_nxt = SCALE;
`else
      FETCH:   state_nxt = PRESENT;
`endif
      SCALE:   state_nxt = PRESENT;
      PRESENT: state_nxt = LOAD;
      LOAD:    if (drv_done) state_nxt = GAP;
      GAP:     state_nxt = (idx == LAST_IDX) ? LATCH : FETCH;
      LATCH:   if (lcnt == LATCH_END) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The word is already on drv_rgb during PRESENT, one cycle before load rises.
  assign drv_rgb    = (state == PRESENT) ? pix : rgb_hold;
  assign drv_load   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
